// File: rtl/int_src_ctrl_if.sv
// Interrupt source bundle between external lines / software registers and
// the int_src_ctrl block.
//   raw_irq  : asynchronous active-high interrupt lines
//   irq_mask : per-channel enable
//   pend_clr : write-1-to-clear for pend
//   intsrc   : one-cycle request pulses toward CP0 (bit 2 highest priority)
//   pend     : sticky record of issued pulses
interface int_src_ctrl_if;
    logic [2:0] raw_irq;
    logic [2:0] irq_mask;
    logic [2:0] pend_clr;
    logic [2:0] intsrc;
    logic [2:0] pend;

    modport master (
        output raw_irq,
        output irq_mask,
        output pend_clr,
        input  intsrc,
        input  pend
    );

    modport slave (
        input  raw_irq,
        input  irq_mask,
        input  pend_clr,
        output intsrc,
        output pend
    );
endinterface

// File: rtl/int_src_ctrl.sv
// Three-channel external interrupt conditioner.
// Each raw line is synchronized, optionally debounced, and a masked rising
// edge of the accepted level produces a one-cycle intsrc pulse plus a sticky
// pend bit that software clears with pend_clr (set wins over clear).
// Optional feature: define INTSRC_DEBOUNCE_EN to require DEBOUNCE_CYCLES
// consecutive differing samples before a level change is accepted; without
// it the accepted level follows the synchronizer every cycle.
module int_src_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    int_src_ctrl_if.slave  bus
);

    // Reject out-of-range configurations at elaboration.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("int_src_ctrl: DEBOUNCE_CYCLES must be in 1..65535");
    end

    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] stable;
    logic [2:0] stable_nxt;
    logic [2:0] rise;
    logic [2:0] intsrc_q;
    logic [2:0] pend_q;

    // Two-flop synchronizer; the only reader of raw_irq.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.raw_irq;
            s2 <= s1;
        end
    end

`ifdef INTSRC_DEBOUNCE_EN
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [2:0][15:0] cnt;
    logic [2:0][15:0] cnt_nxt;

    for (genvar ch = 0; ch < 3; ch++) begin : g_deb
        // Count consecutive samples that disagree with the accepted level;
        // accept the new level on the sample that completes the run.
        always_comb begin
            stable_nxt[ch] = stable[ch];
            cnt_nxt[ch]    = '0;
            if (s2[ch] != stable[ch]) begin
                if (cnt[ch] == CNT_MAX) begin
                    stable_nxt[ch] = s2[ch];
                end else begin
                    cnt_nxt[ch] = cnt[ch] + 16'd1;
                end
            end
        end
    end

    // Debounce counters; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    assign stable_nxt = s2;
`endif

    // A pulse is due only on an accepted 0->1 change while enabled; a masked
    // rise still updates stable, so it is dropped rather than deferred.
    assign rise = stable_nxt & ~stable & bus.irq_mask;

    // Accepted level, request pulse and sticky pending state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable   <= '0;
            intsrc_q <= '0;
            pend_q   <= '0;
        end else begin
            stable   <= stable_nxt;
            intsrc_q <= rise;
            pend_q   <= (pend_q & ~bus.pend_clr) | rise;
        end
    end

    assign bus.intsrc = intsrc_q;
    assign bus.pend   = pend_q;

endmodule

// File: doc/int_src_ctrl.md
INT_SRC_CTRL -- requirements
Module: int_src_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable samples needed before a level change is accepted (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port raw_irq  input  3  asynchronous external interrupt lines (keys or peripherals), active-high.
REQ-005 SHALL have port irq_mask  input  3  per-channel enable, synchronous to clk.
REQ-006 SHALL have port pend_clr  input  3  write-1-to-clear for pend, synchronous.
REQ-007 SHALL have port intsrc  output  3  registered one-cycle request pulses feeding CP0 intsrc; bit 2 is highest priority.
REQ-008 SHALL have port pend  output  3  sticky record of issued pulses, for software polling.

Function
REQ-009 Each channel i SHALL pass raw_irq[i] through a two-flop synchronizer (s1, s2); no other logic reads raw_irq.
REQ-010 Each channel SHALL hold an accepted level stable[i] and a counter cnt[i] of 16 bits.
REQ-011 When s2[i] == stable[i] on an edge, cnt[i] SHALL load 0.
REQ-012 When s2[i] != stable[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-013 When s2[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1, stable[i] SHALL load s2[i] and cnt[i] SHALL load 0 on that edge.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no stable change and no pulse.
REQ-015 On the edge where stable[i] goes 0->1 and irq_mask[i] == 1, intsrc[i] SHALL be 1 for exactly one cycle; falling transitions SHALL never pulse.
REQ-016 A rising transition while irq_mask[i] == 0 SHALL be discarded, not deferred; unmasking later SHALL not create a pulse.
REQ-017 Latency SHALL be DEBOUNCE_CYCLES+2 rising edges from the first edge sampling raw_irq high to intsrc[i] registered high.
REQ-018 Channels SHALL be independent; simultaneous pulses on several bits SHALL be issued in the same cycle without arbitration (CP0 prioritizes).
REQ-019 pend[i] SHALL set on the edge intsrc[i] is registered high, clear on edge with pend_clr[i] == 1; simultaneous set and clear SHALL leave pend[i] = 1.
REQ-020 A held-high raw_irq SHALL produce one pulse only; a new pulse requires a debounced low then high.

Reset
REQ-021 rst low SHALL asynchronously force s1, s2, stable, cnt, intsrc and pend to 0.
REQ-022 Reset deasserted while raw_irq is high SHALL be treated as a new rising event and pulse after REQ-017 latency.
REQ-023 Reset mid-count SHALL abort the count with no pulse.

Configuration
REQ-024 With macro INTSRC_DEBOUNCE_EN defined, REQ-010..REQ-014 SHALL apply as stated.
REQ-025 Without INTSRC_DEBOUNCE_EN, cnt SHALL not exist, stable[i] SHALL load s2[i] every edge, and latency SHALL be 3 edges regardless of DEBOUNCE_CYCLES.

Verification
REQ-026 DEBOUNCE_CYCLES=4, mask=3'b111, raw_irq[2] 0->1 held -> intsrc=3'b100 one cycle, 6 edges after first high sample; pend=3'b100 after.
REQ-027 raw_irq[0] high for 3 synchronized cycles then low -> intsrc stays 3'b000, pend stays 3'b000.
REQ-028 raw_irq rises on bits 2 and 0 on same edge -> intsrc=3'b101 for one cycle.
REQ-029 mask=3'b110, raw_irq[0] rises -> no pulse; mask set to 3'b111 while raw still high -> still no pulse.
REQ-030 pend=3'b100, pend_clr=3'b100 on the same edge as a new bit-2 pulse -> pend remains 3'b100; next pend_clr alone -> pend=3'b000.
REQ-031 rst low during count, raw_irq low before release -> all outputs 0, no pulse; build without INTSRC_DEBOUNCE_EN -> 3-edge latency, 1-cycle glitch pulses.
